// File: rtl/pattern_gen.sv
// Purpose: multi-mode test-pattern generator (count/square/lfsr/alternate/walk) feeding the capture self-test path.
// Latency: first sample is valid the cycle after start; one new sample per enabled RUN cycle thereafter.
// Backpressure: none; enable=0 pauses the run (state frozen, data_valid low), stop aborts to IDLE.
module pattern_gen #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    CNT_WIDTH  = 16,
  parameter logic [DATA_WIDTH-1:0] LFSR_TAPS  = 8'hB8,
  parameter logic [DATA_WIDTH-1:0] LFSR_SEED  = 8'hA5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  enable,
  input  logic [2:0]            mode,
  input  logic [DATA_WIDTH-1:0] step,
  input  logic [CNT_WIDTH-1:0]  period,
  input  logic [CNT_WIDTH-1:0]  duty,
  input  logic [CNT_WIDTH-1:0]  burst_len,
  output logic [DATA_WIDTH-1:0] test_data,
  output logic                  data_valid,
  output logic                  busy,
  output logic                  done
);

  localparam logic [2:0] MODE_COUNT  = 3'b000;
  localparam logic [2:0] MODE_SQUARE = 3'b001;
  localparam logic [2:0] MODE_LFSR   = 3'b010;
  localparam logic [2:0] MODE_ALT    = 3'b011;
  localparam logic [2:0] MODE_WALK1  = 3'b100;
  localparam logic [2:0] MODE_WALK0  = 3'b101;

  localparam logic [DATA_WIDTH-1:0] ONES    = {DATA_WIDTH{1'b1}};
  localparam logic [DATA_WIDTH-1:0] ONE_HOT = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX = {CNT_WIDTH{1'b1}};

  // Alternating pattern ...1010 with the LSB clear, sized to DATA_WIDTH.
  function automatic logic [DATA_WIDTH-1:0] alt_pattern();
    logic [DATA_WIDTH-1:0] p;
    p = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      p[i] = i[0];
    end
    return p;
  endfunction

  localparam logic [DATA_WIDTH-1:0] ALT_A = alt_pattern();

  typedef enum logic {IDLE, RUN} state_t;

  state_t                state_q, state_d;

  // Configuration captured at start so the run is immune to input changes.
  logic [2:0]            mode_q;
  logic [DATA_WIDTH-1:0] step_q;
  logic [CNT_WIDTH-1:0]  period_q;     // already clamped to >= 1
  logic [CNT_WIDTH-1:0]  duty_q;
  logic [CNT_WIDTH-1:0]  burst_q;

  logic [DATA_WIDTH-1:0] data_q;
  logic                  data_valid_q;
  logic                  done_q;
  logic [CNT_WIDTH-1:0]  phase_q;
  logic [CNT_WIDTH-1:0]  sample_cnt_q; // samples emitted in this run

  logic                  load;         // IDLE -> RUN: latch config, emit sample 0
  logic                  advance;      // emit next sample
  logic                  finish;       // burst complete, pulse done
  logic                  last_emitted;

  logic [DATA_WIDTH-1:0] init_data;
  logic [DATA_WIDTH-1:0] next_data;
  logic [DATA_WIDTH-1:0] lfsr_shift;
  logic [CNT_WIDTH-1:0]  phase_next;
  logic [CNT_WIDTH-1:0]  sample_cnt_next;

  // Burst ends once the sample counter has reached the latched length;
  // continuous runs (length 0) never end on their own.
  assign last_emitted = (burst_q != '0) && (sample_cnt_q == burst_q);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and control strobes; stop has priority over burst completion.
  // Completion does not wait for enable: the last sample has already gone out.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    advance = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d = RUN;
          load    = 1'b1;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
        end else if (last_emitted) begin
          state_d = IDLE;
          finish  = 1'b1;
        end else if (enable) begin
          advance = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // First sample of a run, taken from the live inputs at the start edge.
  always_comb begin
    init_data = '0;
    case (mode)
      MODE_COUNT:  init_data = '0;
      MODE_SQUARE: init_data = (duty != '0) ? ONES : '0;
      MODE_LFSR:   init_data = LFSR_SEED;
      MODE_ALT:    init_data = ALT_A;
      MODE_WALK1:  init_data = ONE_HOT;
      MODE_WALK0:  init_data = ~ONE_HOT;
      default:     init_data = '0;
    endcase
  end

  assign lfsr_shift = {data_q[DATA_WIDTH-2:0], ^(data_q & LFSR_TAPS)};

  // Square-wave phase wraps at the clamped period.
  assign phase_next = (phase_q >= period_q - CNT_ONE) ? '0 : phase_q + CNT_ONE;

  // Sample counter saturates so long continuous runs never wrap into a false "done".
  assign sample_cnt_next = (sample_cnt_q == CNT_MAX) ? sample_cnt_q : sample_cnt_q + CNT_ONE;

  // Successor sample for the latched mode.
  always_comb begin
    next_data = '0;
    case (mode_q)
      MODE_COUNT:  next_data = data_q + step_q;
      MODE_SQUARE: next_data = (phase_next < duty_q) ? ONES : '0;
      MODE_LFSR:   next_data = (lfsr_shift == '0) ? LFSR_SEED : lfsr_shift;
      MODE_ALT:    next_data = ~data_q;
      MODE_WALK1,
      MODE_WALK0:  next_data = {data_q[DATA_WIDTH-2:0], data_q[DATA_WIDTH-1]};
      default:     next_data = '0;
    endcase
  end

  // Datapath, configuration and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q       <= '0;
      step_q       <= '0;
      period_q     <= '0;
      duty_q       <= '0;
      burst_q      <= '0;
      data_q       <= '0;
      data_valid_q <= 1'b0;
      done_q       <= 1'b0;
      phase_q      <= '0;
      sample_cnt_q <= '0;
    end else begin
      data_valid_q <= load | advance;
      done_q       <= finish;
      if (load) begin
        mode_q       <= mode;
        step_q       <= step;
        period_q     <= (period == '0) ? CNT_ONE : period;
        duty_q       <= duty;
        burst_q      <= burst_len;
        data_q       <= init_data;
        phase_q      <= '0;
        sample_cnt_q <= CNT_ONE;
      end else if (advance) begin
        data_q       <= next_data;
        phase_q      <= phase_next;
        sample_cnt_q <= sample_cnt_next;
      end
    end
  end

  assign test_data  = data_q;
  assign data_valid = data_valid_q;
  assign done       = done_q;
  assign busy       = (state_q == RUN);

endmodule

// File: tb/tb_pattern_gen.sv
// Directed bench for pattern_gen: an 8-bit default instance and a 4-bit instance
// whose LFSR taps/seed drive the next state to zero so the seed reload is exercised.
module tb_pattern_gen;

  logic        clk = 1'b0;
  logic        rst, start8, start4, stop, enable;
  logic [2:0]  mode;
  logic [7:0]  step8;
  logic [3:0]  step4;
  logic [15:0] period, duty, burst_len;

  logic [7:0]  data8;
  logic        dv8, busy8, done8;
  logic [3:0]  data4;
  logic        dv4, busy4, done4;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pattern_gen u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .stop(stop), .enable(enable),
    .mode(mode), .step(step8), .period(period), .duty(duty), .burst_len(burst_len),
    .test_data(data8), .data_valid(dv8), .busy(busy8), .done(done8)
  );

  pattern_gen #(
    .DATA_WIDTH(4), .CNT_WIDTH(16), .LFSR_TAPS(4'h1), .LFSR_SEED(4'h2)
  ) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .stop(stop), .enable(enable),
    .mode(mode), .step(step4), .period(period), .duty(duty), .burst_len(burst_len),
    .test_data(data4), .data_valid(dv4), .busy(busy4), .done(done4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic exp8(input string tag, input logic [7:0] v);
    chk({tag, " vld"}, {31'd0, dv8}, 32'd1);
    chk(tag, {24'd0, data8}, {24'd0, v});
    tick();
  endtask

  task automatic exp4(input string tag, input logic [3:0] v);
    chk({tag, " vld"}, {31'd0, dv4}, 32'd1);
    chk(tag, {28'd0, data4}, {28'd0, v});
    tick();
  endtask

  task automatic go8(input logic [2:0] m, input logic [7:0] s,
                     input logic [15:0] p, input logic [15:0] d, input logic [15:0] l);
    mode = m; step8 = s; period = p; duty = d; burst_len = l;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
  endtask

  task automatic go4(input logic [2:0] m, input logic [15:0] l);
    mode = m; step4 = 4'd0; period = 16'd0; duty = 16'd0; burst_len = l;
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
  endtask

  task automatic end8(input string tag);
    chk({tag, " done"}, {31'd0, done8}, 32'd1);
    chk({tag, " busy"}, {31'd0, busy8}, 32'd0);
    chk({tag, " vld"},  {31'd0, dv8},   32'd0);
    tick();
    chk({tag, " done1cyc"}, {31'd0, done8}, 32'd0);
  endtask

  task automatic end4(input string tag);
    chk({tag, " done"}, {31'd0, done4}, 32'd1);
    chk({tag, " busy"}, {31'd0, busy4}, 32'd0);
    tick();
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] sq;
    rst = 1'b1; start8 = 1'b0; start4 = 1'b0; stop = 1'b0; enable = 1'b1;
    mode = 3'd0; step8 = 8'd0; step4 = 4'd0; period = 16'd0; duty = 16'd0; burst_len = 16'd0;
    tick(); tick();
    chk("rst data8", {24'd0, data8}, 32'd0);
    chk("rst dv8",   {31'd0, dv8},   32'd0);
    chk("rst busy8", {31'd0, busy8}, 32'd0);
    chk("rst done8", {31'd0, done8}, 32'd0);
    chk("rst data4", {28'd0, data4}, 32'd0);
    chk("rst busy4", {31'd0, busy4}, 32'd0);
    rst = 1'b0;

    // Count, step 3, burst 5; a config change mid-run must be ignored.
    go8(3'd0, 8'd3, 16'd0, 16'd0, 16'd5);
    step8 = 8'h11;
    chk("cnt busy", {31'd0, busy8}, 32'd1);
    for (int k = 0; k < 5; k++) exp8("cnt3", 8'(3 * k));
    chk("cnt3 done", {31'd0, done8}, 32'd1);
    chk("cnt3 busy", {31'd0, busy8}, 32'd0);
    chk("cnt3 vld",  {31'd0, dv8},   32'd0);
    // Back-to-back start in the done cycle, step 0x80 wraps.
    go8(3'd0, 8'h80, 16'd0, 16'd0, 16'd4);
    exp8("wrap0", 8'h00); exp8("wrap1", 8'h80); exp8("wrap2", 8'h00); exp8("wrap3", 8'h80);
    end8("wrap");

    // Square waves.
    go8(3'd1, 8'd0, 16'd4, 16'd1, 16'd8);
    for (int k = 0; k < 8; k++) begin
      sq = (k % 4 == 0) ? 8'hFF : 8'h00;
      exp8("sq41", sq);
    end
    end8("sq41");
    go8(3'd1, 8'd0, 16'd0, 16'd1, 16'd3);
    exp8("sqp0", 8'hFF); exp8("sqp0", 8'hFF); exp8("sqp0", 8'hFF);
    end8("sqp0");
    go8(3'd1, 8'd0, 16'd4, 16'd0, 16'd3);
    exp8("sqd0", 8'h00); exp8("sqd0", 8'h00); exp8("sqd0", 8'h00);
    end8("sqd0");
    go8(3'd1, 8'd0, 16'd2, 16'd5, 16'd3);
    exp8("sqdbig", 8'hFF); exp8("sqdbig", 8'hFF); exp8("sqdbig", 8'hFF);
    end8("sqdbig");

    // LFSR with default taps/seed: A5 -> 4A -> 95 -> 2A.
    go8(3'd2, 8'd0, 16'd0, 16'd0, 16'd4);
    exp8("lfsr0", 8'hA5); exp8("lfsr1", 8'h4A); exp8("lfsr2", 8'h95); exp8("lfsr3", 8'h2A);
    end8("lfsr");

    // Walk-0 and reserved mode.
    go8(3'd5, 8'd0, 16'd0, 16'd0, 16'd3);
    exp8("walk0", 8'hFE); exp8("walk0", 8'hFD); exp8("walk0", 8'hFB);
    end8("walk0");
    go8(3'd6, 8'd0, 16'd0, 16'd0, 16'd2);
    exp8("resv", 8'h00); exp8("resv", 8'h00);
    end8("resv");

    // 4-bit instance: LFSR reaching zero reloads the seed, walk-1, alternate.
    go4(3'd2, 16'd5);
    exp4("lfsr4", 4'h2); exp4("lfsr4", 4'h4); exp4("lfsr4", 4'h8); exp4("lfsr4 reload", 4'h2); exp4("lfsr4", 4'h4);
    end4("lfsr4");
    go4(3'd4, 16'd6);
    exp4("walk1", 4'h1); exp4("walk1", 4'h2); exp4("walk1", 4'h4);
    exp4("walk1", 4'h8); exp4("walk1", 4'h1); exp4("walk1", 4'h2);
    end4("walk1");
    go4(3'd3, 16'd4);
    exp4("alt", 4'hA); exp4("alt", 4'h5); exp4("alt", 4'hA); exp4("alt", 4'h5);
    end4("alt");

    // Continuous count with a 3-cycle pause after sample 2, then stop.
    go8(3'd0, 8'd1, 16'd0, 16'd0, 16'd0);
    exp8("cont", 8'd0); exp8("cont", 8'd1);
    chk("cont s2 vld", {31'd0, dv8}, 32'd1);
    chk("cont s2", {24'd0, data8}, 32'd2);
    enable = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("pause vld",  {31'd0, dv8},   32'd0);
      chk("pause data", {24'd0, data8}, 32'd2);
      chk("pause busy", {31'd0, busy8}, 32'd1);
      if (i == 2) enable = 1'b1;
      tick();
    end
    exp8("resume", 8'd3);
    chk("pre-stop", {24'd0, data8}, 32'd4);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop busy", {31'd0, busy8}, 32'd0);
    chk("stop vld",  {31'd0, dv8},   32'd0);
    chk("stop done", {31'd0, done8}, 32'd0);
    chk("stop hold", {24'd0, data8}, 32'd4);
    tick();
    chk("stop done2", {31'd0, done8}, 32'd0);
    chk("stop hold2", {24'd0, data8}, 32'd4);

    // Stop on the edge that would end the burst: no done pulse.
    go8(3'd0, 8'd1, 16'd0, 16'd0, 16'd3);
    exp8("lastst", 8'd0); exp8("lastst", 8'd1);
    chk("lastst s2", {24'd0, data8}, 32'd2);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("lastst done", {31'd0, done8}, 32'd0);
    chk("lastst busy", {31'd0, busy8}, 32'd0);
    tick();
    chk("lastst done2", {31'd0, done8}, 32'd0);

    // Start during RUN is ignored, then a mid-run reset clears everything.
    go8(3'd0, 8'd2, 16'd0, 16'd0, 16'd10);
    chk("rerun s0", {24'd0, data8}, 32'd0);
    start8 = 1'b1; mode = 3'd1; step8 = 8'd5;
    tick();
    start8 = 1'b0;
    chk("rerun s1 vld", {31'd0, dv8}, 32'd1);
    chk("rerun s1", {24'd0, data8}, 32'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst data", {24'd0, data8}, 32'd0);
    chk("midrst vld",  {31'd0, dv8},   32'd0);
    chk("midrst busy", {31'd0, busy8}, 32'd0);
    chk("midrst done", {31'd0, done8}, 32'd0);

    // start with stop in IDLE, and start under reset: stays IDLE.
    start8 = 1'b1; stop = 1'b1;
    tick();
    start8 = 1'b0; stop = 1'b0;
    chk("ststop busy", {31'd0, busy8}, 32'd0);
    chk("ststop vld",  {31'd0, dv8},   32'd0);
    rst = 1'b1; start8 = 1'b1;
    tick();
    rst = 1'b0; start8 = 1'b0;
    chk("rststart busy", {31'd0, busy8}, 32'd0);
    chk("rststart vld",  {31'd0, dv8},   32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
